// File: rtl/stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : stream_checker
// Description : Sink-side checker for an incrementing addr/data beat stream.
//               Compares each accepted beat against internal expected counters,
//               counts mismatches, captures the first failing beat and reports
//               PASS/FAIL after CHECK_LEN beats.
//               Optional macro STREAM_CHECKER_BP_EN: LFSR-driven in_ready
//               backpressure while running.
// Revision    : 1.0  initial release
// ============================================================================
module stream_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CHECK_LEN  = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           beat_cnt,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_PASS = 2'd2;
    localparam logic [1:0]  S_FAIL = 2'd3;

    localparam logic [15:0] C_LAST_BEAT = 16'(CHECK_LEN - 1);
    localparam logic [15:0] C_ERR_MAX   = 16'hFFFF;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;

    logic [ADDR_WIDTH-1:0] r_exp_addr;
    logic [DATA_WIDTH-1:0] r_exp_data;
    logic [15:0]           r_beat_cnt;
    logic [15:0]           r_err_cnt;
    logic [ADDR_WIDTH-1:0] r_first_err_addr;
    logic [DATA_WIDTH-1:0] r_first_err_data;

    logic                  w_run_ready;
    logic                  w_accept;
    logic                  w_start_run;
    logic                  w_mismatch;
    logic                  w_last_beat;

    assign w_accept    = in_valid & in_ready;
    assign w_start_run = start & (r_state != S_RUN);
    assign w_mismatch  = (in_addr != r_exp_addr) | (in_data != r_exp_data);
    assign w_last_beat = w_accept & (r_beat_cnt == C_LAST_BEAT);

`ifdef STREAM_CHECKER_BP_EN
    // Fibonacci LFSR x^8+x^6+x^5+x^4+1; reseeded on each run so the ready pattern is repeatable.
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_lfsr <= 8'hA5;
        end else if (w_start_run) begin
            r_lfsr <= 8'hA5;
        end else if (r_state == S_RUN) begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    assign w_run_ready = r_lfsr[0];
`else
    assign w_run_ready = 1'b1;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_last_beat) begin
                    if ((r_err_cnt == 16'd0) && !w_mismatch) w_state_next = S_PASS;
                    else                                      w_state_next = S_FAIL;
                end
            end
            S_PASS, S_FAIL: begin
                if (start) w_state_next = S_RUN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        pass     = 1'b0;
        case (r_state)
            S_RUN: begin
                busy     = 1'b1;
                in_ready = w_run_ready;
            end
            S_PASS: begin
                done = 1'b1;
                pass = 1'b1;
            end
            S_FAIL: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Expected counters advance even on a mismatch so a single bad beat never desynchronises the run.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_exp_addr       <= '0;
            r_exp_data       <= '0;
            r_beat_cnt       <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_first_err_data <= '0;
        end else if (w_start_run) begin
            r_exp_addr       <= '0;
            r_exp_data       <= '0;
            r_beat_cnt       <= '0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_first_err_data <= '0;
        end else if (w_accept) begin
            r_exp_addr <= r_exp_addr + 1'b1;
            r_exp_data <= r_exp_data + 1'b1;
            r_beat_cnt <= r_beat_cnt + 16'd1;
            if (w_mismatch) begin
                if (r_err_cnt != C_ERR_MAX) r_err_cnt <= r_err_cnt + 16'd1;
                if (r_err_cnt == 16'd0) begin
                    r_first_err_addr <= in_addr;
                    r_first_err_data <= in_data;
                end
            end
        end
    end

    assign beat_cnt       = r_beat_cnt;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err_addr;
    assign first_err_data = r_first_err_data;

endmodule
`default_nettype wire

// File: tb/tb_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_checker
// Description : Directed self-checking bench for stream_checker (32-bit default
//               instance plus an 8-bit-data, 300-beat instance for wrap checks).
// Revision    : 1.0  initial release
// ============================================================================
module tb_stream_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start8;
    logic        in_valid;
    logic [31:0] in_addr, in_data;

    logic        in_ready, busy, done, pass;
    logic [15:0] beat_cnt, err_cnt;
    logic [31:0] first_err_addr, first_err_data;

    logic        in_ready8, busy8, done8, pass8;
    logic [15:0] beat_cnt8, err_cnt8;
    logic [31:0] first_err_addr8;
    logic [7:0]  first_err_data8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_checker dut (
        .sys_clk(clk), .sys_rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .busy(busy), .done(done), .pass(pass),
        .beat_cnt(beat_cnt), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data)
    );

    stream_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(32), .CHECK_LEN(300)) dut8 (
        .sys_clk(clk), .sys_rst(rst), .start(start8),
        .in_valid(in_valid), .in_ready(in_ready8),
        .in_addr(in_addr), .in_data(in_data[7:0]),
        .busy(busy8), .done(done8), .pass(pass8),
        .beat_cnt(beat_cnt8), .err_cnt(err_cnt8),
        .first_err_addr(first_err_addr8), .first_err_data(first_err_data8)
    );

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(input bit sel8, input logic [31:0] a, input logic [31:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        while (((sel8 ? in_ready8 : in_ready) !== 1'b1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL handshake_timeout: in_ready stayed low, got %0d cycles, required < 100", t);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_addr  = 32'hDEAD_BEEF;
        in_data  = 32'hCAFE_F00D;
    endtask

    task automatic pulse_start(input bit sel8);
        if (sel8) start8 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start8 = 1'b0;
    endtask

    // mode 0 clean, 1 beat5 data=0x55, 2 beats 3/9 addr^0x100, 3 last beat data corrupt
    task automatic drive_run(input int mode, input int n);
        logic [31:0] a, d;
        for (int i = 0; i < n; i++) begin
            a = i;
            d = i;
            if (mode == 1 && i == 5) d = 32'h55;
            if (mode == 2 && (i == 3 || i == 9)) a = a ^ 32'h100;
            if (mode == 3 && i == n - 1) d = 32'h1234_5678;
            send(1'b0, a, d);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start8 = 1'b0; in_valid = 1'b0;
        in_addr = '0; in_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, busy, done, pass} !== 4'b0000 || beat_cnt !== 16'd0 || err_cnt !== 16'd0 ||
            first_err_addr !== 32'd0 || first_err_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/busy/done/pass=%b beat=%0d err=%0d, required all 0",
                     {in_ready, busy, done, pass}, beat_cnt, err_cnt);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b done=%b rdy=%b, required 0 0 0", busy, done, in_ready);
        end
    endtask

    task automatic test_clean_pass;
        pulse_start(1'b0);
        checks++;
        if (busy !== 1'b1 || beat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL run_entry: got busy=%b beat=%0d, required busy=1 beat=0", busy, beat_cnt);
        end
        drive_run(0, 1023);
        checks++;
        if (done !== 1'b0 || beat_cnt !== 16'd1023) begin
            errors++;
            $display("FAIL pre_last: got done=%b beat=%0d, required done=0 beat=1023", done, beat_cnt);
        end
        send(1'b0, 32'd1023, 32'd1023);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pass_latency: got done=%b pass=%b busy=%b rdy=%b, required 1 1 0 0",
                     done, pass, busy, in_ready);
        end
        checks++;
        if (beat_cnt !== 16'd1024 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL pass_counts: got beat=%0d err=%0d, required beat=1024 err=0", beat_cnt, err_cnt);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (pass !== 1'b1 || beat_cnt !== 16'd1024) begin
            errors++;
            $display("FAIL pass_hold: got pass=%b beat=%0d, required pass=1 beat=1024", pass, beat_cnt);
        end
    endtask

    task automatic test_data_error;
        pulse_start(1'b0);
        checks++;
        if (beat_cnt !== 16'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: got beat=%0d done=%b, required beat=0 done=0", beat_cnt, done);
        end
        drive_run(1, 1024);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL data_err_status: got done=%b pass=%b err=%0d, required 1 0 1", done, pass, err_cnt);
        end
        checks++;
        if (first_err_addr !== 32'd5 || first_err_data !== 32'h55) begin
            errors++;
            $display("FAIL data_err_capture: got addr=%h data=%h, required addr=5 data=55",
                     first_err_addr, first_err_data);
        end
    endtask

    task automatic test_addr_errors;
        pulse_start(1'b0);
        drive_run(2, 1024);
        checks++;
        if (err_cnt !== 16'd2 || pass !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL addr_err_count: got err=%0d pass=%b done=%b, required err=2 pass=0 done=1",
                     err_cnt, pass, done);
        end
        checks++;
        if (first_err_addr !== 32'h103 || first_err_data !== 32'd3) begin
            errors++;
            $display("FAIL addr_err_first: got addr=%h data=%h, required addr=103 data=3",
                     first_err_addr, first_err_data);
        end
        pulse_start(1'b0);
        drive_run(3, 1024);
        checks++;
        if (err_cnt !== 16'd1 || pass !== 1'b0 || done !== 1'b1 || first_err_addr !== 32'd1023) begin
            errors++;
            $display("FAIL last_beat_err: got err=%0d pass=%b done=%b addr=%0d, required 1 0 1 1023",
                     err_cnt, pass, done, first_err_addr);
        end
    endtask

    task automatic test_valid_gaps;
        int gap_fail = 0;
        pulse_start(1'b0);
        for (int i = 0; i < 1024; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_addr  = $urandom;
                in_data  = $urandom;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                if (beat_cnt !== 16'(i)) gap_fail++;
            end
            send(1'b0, i, i);
            if (beat_cnt !== 16'(i + 1)) gap_fail++;
        end
        checks++;
        if (gap_fail != 0) begin
            errors++;
            $display("FAIL gap_beat_track: got %0d beat_cnt deviations, required 0", gap_fail);
        end
        checks++;
        if (pass !== 1'b1 || beat_cnt !== 16'd1024 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL gap_pass: got pass=%b beat=%0d err=%0d, required pass=1 beat=1024 err=0",
                     pass, beat_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_midrun;
        pulse_start(1'b0);
        drive_run(0, 100);
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, done, pass} !== 4'b0000 || beat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset: got rdy/busy/done/pass=%b beat=%0d, required 0000 beat=0",
                     {in_ready, busy, done, pass}, beat_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start(1'b0);
        for (int i = 0; i < 1024; i++) begin
            if (i == 500) pulse_start(1'b0);
            send(1'b0, i, i);
        end
        checks++;
        if (pass !== 1'b1 || beat_cnt !== 16'd1024 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL start_in_run: got pass=%b beat=%0d err=%0d, required pass=1 beat=1024 err=0",
                     pass, beat_cnt, err_cnt);
        end
    endtask

    task automatic test_wrap_width8;
        pulse_start(1'b1);
        checks++;
        if (busy8 !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL w8_start: got busy8=%b busy=%b, required 1 0", busy8, busy);
        end
        for (int i = 0; i < 300; i++) send(1'b1, i, i & 32'hFF);
        checks++;
        if (pass8 !== 1'b1 || done8 !== 1'b1 || beat_cnt8 !== 16'd300 || err_cnt8 !== 16'd0) begin
            errors++;
            $display("FAIL w8_wrap_pass: got pass=%b done=%b beat=%0d err=%0d, required 1 1 300 0",
                     pass8, done8, beat_cnt8, err_cnt8);
        end
        pulse_start(1'b1);
        for (int i = 0; i < 300; i++) send(1'b1, i, (i == 256) ? 32'd256 + 32'd7 : (i & 32'hFF));
        checks++;
        if (pass8 !== 1'b0 || err_cnt8 !== 16'd1 || first_err_addr8 !== 32'd256 || first_err_data8 !== 8'd7) begin
            errors++;
            $display("FAIL w8_wrap_err: got pass=%b err=%0d addr=%0d data=%0d, required 0 1 256 7",
                     pass8, err_cnt8, first_err_addr8, first_err_data8);
        end
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_data_error();
        test_addr_errors();
        test_valid_gaps();
        test_reset_midrun();
        test_wrap_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
